// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scanner: scan FSM states,
// active-low hex glyphs (seg[6:0] = g..a) and the all-off patterns.
package seg7_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
    localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
    localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
    localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
    localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
    localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
    localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
    localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
    localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
    localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
    localparam logic [6:0] SEG_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG_HEX_B = 7'b0000011;
    localparam logic [6:0] SEG_HEX_C = 7'b1000110;
    localparam logic [6:0] SEG_HEX_D = 7'b0100001;
    localparam logic [6:0] SEG_HEX_E = 7'b0000110;
    localparam logic [6:0] SEG_HEX_F = 7'b0001110;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_OFF;
        case (i_hex)
            4'h0: o_seg = SEG_HEX_0;
            4'h1: o_seg = SEG_HEX_1;
            4'h2: o_seg = SEG_HEX_2;
            4'h3: o_seg = SEG_HEX_3;
            4'h4: o_seg = SEG_HEX_4;
            4'h5: o_seg = SEG_HEX_5;
            4'h6: o_seg = SEG_HEX_6;
            4'h7: o_seg = SEG_HEX_7;
            4'h8: o_seg = SEG_HEX_8;
            4'h9: o_seg = SEG_HEX_9;
            4'hA: o_seg = SEG_HEX_A;
            4'hB: o_seg = SEG_HEX_B;
            4'hC: o_seg = SEG_HEX_C;
            4'hD: o_seg = SEG_HEX_D;
            4'hE: o_seg = SEG_HEX_E;
            4'hF: o_seg = SEG_HEX_F;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment scanner with frame-synchronous update.
// Optional decimal-point support is enabled by defining SEVSEG_DP_EN.
module seven_seg_scan
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 16
) (
    input  logic        GLBclk,
    input  logic        reset,
    input  logic [15:0] data,
    input  logic        load,
`ifdef SEVSEG_DP_EN
    input  logic [3:0]  dp_in,
    output logic        dp,
`endif
    output logic        upd_pend,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame_tick
);

    localparam logic [15:0] CNT_LAST  = 16'(SCAN_DIV - 1);
    localparam logic [15:0] BLANK_END = 16'(BLANK_CYC);

    scan_state_t r_state;
    scan_state_t w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic [1:0]  r_dig;
    logic [1:0]  w_dig_nxt;
    logic [15:0] r_active;
    logic [15:0] r_shadow;
    logic        r_wrap;
    logic        w_slot_end;
    logic        w_frame_end;
    logic [3:0]  w_nib;
    logic [3:0]  w_an_nxt;
    logic [6:0]  w_dec;
    logic [6:0]  w_seg_nxt;

    assign w_slot_end  = (r_cnt == CNT_LAST);
    assign w_frame_end = w_slot_end && (r_dig == 2'd3);
    assign w_nib       = r_active[{r_dig, 2'b00} +: 4];

    hex_to_seg7 u_dec (
        .i_hex (w_nib),
        .o_seg (w_dec)
    );

    always_ff @(posedge GLBclk or posedge reset) begin
        if (reset) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
            r_dig   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dig   <= w_dig_nxt;
        end
    end

    // State follows the next counter value so r_state always matches r_cnt.
    always_comb begin
        w_cnt_nxt   = w_slot_end ? 16'd0 : r_cnt + 16'd1;
        w_dig_nxt   = w_slot_end ? r_dig + 2'd1 : r_dig;
        w_state_nxt = (w_cnt_nxt < BLANK_END) ? ST_BLANK : ST_DRIVE;
        w_an_nxt    = AN_OFF;
        w_seg_nxt   = SEG_OFF;
        if (r_state == ST_DRIVE) begin
            w_an_nxt  = ~(4'b0001 << r_dig);
            w_seg_nxt = w_dec;
        end
    end

    // Active only changes at the digit-3 wrap, so a frame is never mixed.
    always_ff @(posedge GLBclk or posedge reset) begin
        if (reset) begin
            r_active   <= '0;
            r_shadow   <= '0;
            upd_pend   <= 1'b0;
            r_wrap     <= 1'b0;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            frame_tick <= 1'b0;
        end else begin
            an         <= w_an_nxt;
            seg        <= w_seg_nxt;
            r_wrap     <= w_frame_end;
            frame_tick <= r_wrap;
            if (w_frame_end && upd_pend) begin
                r_active <= r_shadow;
            end
            if (load) begin
                r_shadow <= data;
                upd_pend <= 1'b1;
            end else if (w_frame_end) begin
                upd_pend <= 1'b0;
            end
        end
    end

`ifdef SEVSEG_DP_EN
    logic [3:0] r_dp_shadow;
    logic [3:0] r_dp_active;

    always_ff @(posedge GLBclk or posedge reset) begin
        if (reset) begin
            r_dp_shadow <= '0;
            r_dp_active <= '0;
            dp          <= 1'b1;
        end else begin
            dp <= (r_state == ST_DRIVE) ? ~r_dp_active[r_dig] : 1'b1;
            if (w_frame_end && upd_pend) begin
                r_dp_active <= r_dp_shadow;
            end
            if (load) begin
                r_dp_shadow <= dp_in;
            end
        end
    end
`endif

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, GLBclk cycles per digit slot (legal range: BLANK_CYC+1 to 65535).
REQ-002 SHALL have parameter BLANK_CYC, default 16, all-anodes-off cycles at the start of each slot (legal range: 1 to SCAN_DIV-1).
REQ-003 SHALL have port GLBclk  input  1  single clock for all logic (50 MHz board clock).
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port data  input  16  four hex nibbles; data[3:0] maps to digit 0 (rightmost).
REQ-006 SHALL have port load  input  1  one-cycle strobe that captures data into the shadow register.
REQ-007 SHALL have port upd_pend  output  1  high while a captured value awaits frame boundary.
REQ-008 SHALL have port an  output  4  active-low anode enables; an[i] drives digit i.
REQ-009 SHALL have port seg  output  7  active-low segments, seg[0]=a through seg[6]=g.
REQ-010 SHALL have port frame_tick  output  1  one-cycle pulse at each digit-3-to-0 wrap.

Function
REQ-011 SHALL run a slot counter 0..SCAN_DIV-1 that advances every GLBclk cycle and wraps to 0.
REQ-012 SHALL use FSM states BLANK and DRIVE: BLANK while the counter is below BLANK_CYC, otherwise DRIVE.
REQ-013 SHALL hold an=4'b1111 and seg=7'b1111111 in BLANK, for anti-ghosting.
REQ-014 SHALL drive, in DRIVE, an with only bit [digit] low and seg with the decode of the active nibble for digit.
REQ-015 SHALL increment digit (2 bits, 0..3, wrap 3->0) on counter wrap; the FSM then re-enters BLANK.
REQ-016 SHALL register all outputs, with one cycle of latency from counter/state to an/seg.
REQ-017 SHALL set shadow<=data and upd_pend<=1 on load, visible on the next cycle.
REQ-018 SHALL let the latest data win when load occurs while upd_pend=1; the earlier value is discarded.
REQ-019 SHALL, at the 3->0 wrap with upd_pend=1, copy shadow to active and clear upd_pend, so frames are never torn.
REQ-020 SHALL, when load and the 3->0 wrap coincide, transfer the previous shadow, capture the new data, and leave upd_pend=1.
REQ-021 SHALL pulse frame_tick high for exactly one cycle, aligned with the first BLANK cycle of digit 0.
REQ-022 SHALL decode hex 0-F to standard seven-segment patterns: 0=7'b1000000, 8=7'b0000000, F=7'b0001110 (seg[6:0], active-low).

Reset
REQ-023 SHALL, on reset high, asynchronously force: counter=0, digit=0, state=BLANK, active=0, shadow=0, upd_pend=0, an=4'b1111, seg=7'b1111111, frame_tick=0 (and dp=1 when SEVSEG_DP_EN is defined).
REQ-024 SHALL abandon any scan in progress when reset asserts mid-slot; after release, the first DRIVE slot is digit 0, showing "0000".
REQ-025 SHALL drop a load that coincides with reset.

Configuration
REQ-026 SHALL, with macro SEVSEG_DP_EN defined, add input dp_in[3:0] (captured and transferred with data) and output dp (active-low, low in DRIVE when dp_in[digit]=1, high in BLANK).
REQ-027 SHALL, without SEVSEG_DP_EN, have no dp_in or dp ports and no related logic.

Structure
REQ-028 SHALL place in shared package seg7_pkg: the FSM state encoding, the 16 segment-pattern constants, and the all-off constants for an and seg.
REQ-029 SHALL contain one combinational sub-module, hex_to_seg7 (4-bit in, 7-bit active-low out), instanced once.

Verification (SCAN_DIV=8, BLANK_CYC=2)
REQ-030 SHALL check reset: assert reset mid-DRIVE -> an=1111 and seg=1111111 in the same cycle; after release, digit 0 shows 7'b1000000 from cycle 3.
REQ-031 SHALL check scan order: load data=16'h1234 and wait one frame -> digits 0..3 show 4,3,2,1 in order; an low pattern 1110,1101,1011,0111; 2 blank cycles precede each 6 drive cycles.
REQ-032 SHALL check no tearing: load 16'hABCD during digit 1 -> the rest of the frame still shows the old value; upd_pend=1 until the wrap; the next frame shows D,C,B,A.
REQ-033 SHALL check overwrite: load 16'h1111 then 16'h2222 within one frame -> only "2222" is displayed.
REQ-034 SHALL check coincidence: load 16'h5555 on the wrap cycle while the shadow holds 16'h4444 -> "4444" is displayed and upd_pend stays 1; "5555" appears next frame.
REQ-035 SHALL check frame_tick: exactly one pulse every 32 cycles, coincident with the first BLANK cycle of digit 0.
